// File: rtl/result_collector_pkg.sv
// Shared definitions for the serial result collector.
// State encodings, default widths and the x0 register index.
package result_collector_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 6;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PAD     = 2'd2,
      ST_HOLD    = 2'd3
   } rc_state_t;

endpackage

// File: rtl/result_collector_counter.sv
// Loadable up/down counter used as the captured-bit counter.
// Load has priority over counting.
module result_collector_counter #(
   parameter bit COUNT_DOWN  = 1'b0,
   parameter int COUNT_WIDTH = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] load_val,
   input  logic                   count_en,
   output logic [COUNT_WIDTH-1:0] count
);

   // count register: reset, load or step
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count_en) begin
         if (COUNT_DOWN)
            count <= count - 1'b1;
         else
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/result_collector.sv
// Collects the LSB-first serial result bus into a word, pads short
// windows and offers the word to the register file over valid/ready.
module result_collector
   import result_collector_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      rd_addr,
   input  logic            fill_sign,
   input  logic            bit_in,
   input  logic            bit_en,
   input  logic [5:0]      bit_pos,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_addr,
   output logic            busy,
   output logic            overrun
);

   rc_state_t        state;
   logic [XLEN-1:0]  shreg;
   logic [4:0]       rd_q;
   logic             fill_q;
   logic             last_q;
   logic [CNT_W-1:0] count;

   logic             in_collect;
   logic             in_pad;
   logic             in_hold;
   logic             handshake;
   logic             restart;
   logic             accept;
   logic             step;
   logic             full;
   logic             shin;
   logic [XLEN-1:0]  shnext;
   logic             unused_pos;

   assign unused_pos = ^bit_pos[4:0];

   assign in_collect = (state == ST_COLLECT);
   assign in_pad     = (state == ST_PAD);
   assign in_hold    = (state == ST_HOLD);
   assign handshake  = in_hold & wb_ready;

   // a start is honoured in IDLE, COLLECT (abort) and on a HOLD handshake
   assign restart = start &
      ((state == ST_IDLE) | in_collect | handshake);

   assign accept = in_collect & bit_en & ~start;
   assign step   = (accept | in_pad) & (count != CNT_W'(XLEN));
   assign full   = step & (count == CNT_W'(XLEN - 1));

   // last_q is cleared on start, so a pad with no bits received is zero
   assign shin   = accept ? bit_in : (fill_q & last_q);
   assign shnext = {shin, shreg[XLEN-1:1]};

   result_collector_counter #(
      .COUNT_DOWN  (1'b0),
      .COUNT_WIDTH (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (restart),
      .load_val ('0),
      .count_en (step),
      .count    (count)
   );

   // control FSM with shift register and registered writeback outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         rd_q     <= '0;
         fill_q   <= 1'b0;
         last_q   <= 1'b0;
         wb_valid <= 1'b0;
         wb_data  <= '0;
         wb_addr  <= '0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_COLLECT;
                  shreg  <= '0;
                  last_q <= 1'b0;
                  rd_q   <= rd_addr;
                  fill_q <= fill_sign;
                  busy   <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (start) begin
                  shreg  <= '0;
                  last_q <= 1'b0;
                  rd_q   <= rd_addr;
                  fill_q <= fill_sign;
               end else begin
                  if (accept) begin
                     shreg  <= shnext;
                     last_q <= bit_in;
                  end
                  if (full) begin
                     busy <= 1'b0;
                     if (rd_q == REG_ZERO) begin
                        state <= ST_IDLE;
                     end else begin
                        state    <= ST_HOLD;
                        wb_valid <= 1'b1;
                        wb_data  <= shnext;
                        wb_addr  <= rd_q;
                     end
                  end else if (bit_pos[5]) begin
                     state <= ST_PAD;
                  end
               end
            end
            ST_PAD: begin
               if (step)
                  shreg <= shnext;
               if (full) begin
                  busy <= 1'b0;
                  if (rd_q == REG_ZERO) begin
                     state <= ST_IDLE;
                  end else begin
                     state    <= ST_HOLD;
                     wb_valid <= 1'b1;
                     wb_data  <= shnext;
                     wb_addr  <= rd_q;
                  end
               end
            end
            ST_HOLD: begin
               if (handshake) begin
                  wb_valid <= 1'b0;
                  if (start) begin
                     state  <= ST_COLLECT;
                     shreg  <= '0;
                     last_q <= 1'b0;
                     rd_q   <= rd_addr;
                     fill_q <= fill_sign;
                     busy   <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (start) begin
                  overrun <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
